// File: rtl/dispatch_iq.sv
// dispatch_iq: circular instruction queue between decode and the RS/ROB, dispatching the head in order.
// Packet layout is {payload, halt, fu}; an fu value >= NUM_FU is drained without an RS strobe.
module dispatch_iq #(
  parameter int IQ_DEPTH  = 8,
  parameter int NUM_FU    = 4,
  parameter int CNT_W     = 32,
  parameter int FU_W      = 3,
  parameter int PAYLOAD_W = 16,
  parameter int PACK_W    = PAYLOAD_W + 1 + FU_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enq_valid,
  input  logic [PACK_W-1:0]         enq_pack,
  output logic                      enq_ready,
  input  logic                      rob_full,
  input  logic [NUM_FU-1:0]         RS_is_full,
  input  logic                      squash,
  output logic                      dispatch_valid,
  output logic [PACK_W-1:0]         dispatch_pack,
  output logic [NUM_FU-1:0]         RS_load,
  output logic [$clog2(IQ_DEPTH):0] iq_count,
  output logic                      halted,
  output logic [CNT_W-1:0]          rs_stall_cycles,
  output logic [CNT_W-1:0]          rob_stall_cycles
);
  localparam int PTR_W   = $clog2(IQ_DEPTH);
  localparam int CNT_Q_W = PTR_W + 1;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  logic [PACK_W-1:0]  mem_r [IQ_DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_Q_W-1:0] count_r;
  state_t             state_r;
  logic [CNT_W-1:0]   rs_stall_r;
  logic [CNT_W-1:0]   rob_stall_r;

  logic               empty_s;
  logic               full_s;
  logic               run_s;
  logic [PACK_W-1:0]  head_pack_s;
  logic [FU_W-1:0]    head_fu_s;
  logic               head_halt_s;
  logic               fu_legal_s;
  logic               rs_full_s;
  logic               active_s;
  logic               fire_s;
  logic               enq_ready_s;
  logic               push_s;
  logic [NUM_FU-1:0]  rs_load_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Head decode, dispatch decision and enqueue handshake.
  always_comb begin
    empty_s     = (count_r == {CNT_Q_W{1'b0}});
    full_s      = (count_r == CNT_Q_W'(IQ_DEPTH));
    run_s       = (state_r == RUN);
    head_pack_s = mem_r[head_r];
    head_fu_s   = head_pack_s[FU_W-1:0];
    head_halt_s = head_pack_s[FU_W];
    fu_legal_s  = (32'(head_fu_s) < 32'(NUM_FU));
    rs_full_s   = 1'b0;
    rs_load_s   = {NUM_FU{1'b0}};
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_legal_s && (head_fu_s == FU_W'(i))) begin
        rs_full_s = RS_is_full[i];
      end else begin
        rs_full_s = rs_full_s;
      end
    end
    // A head that is present, running and not being squashed either fires or stalls.
    active_s    = !empty_s && run_s && !squash && !reset;
    fire_s      = active_s && !rob_full && !rs_full_s;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fire_s && fu_legal_s && (head_fu_s == FU_W'(i))) begin
        rs_load_s[i] = 1'b1;
      end else begin
        rs_load_s[i] = 1'b0;
      end
    end
    enq_ready_s = run_s && !full_s && !squash && !reset;
    push_s      = enq_valid && enq_ready_s;
  end

  assign enq_ready        = enq_ready_s;
  assign dispatch_valid   = fire_s;
  assign dispatch_pack    = (empty_s || reset) ? {PACK_W{1'b0}} : head_pack_s;
  assign RS_load          = rs_load_s;
  assign iq_count         = reset ? {CNT_Q_W{1'b0}} : count_r;
  assign halted           = !reset && (state_r == HALTED);
  assign rs_stall_cycles  = reset ? {CNT_W{1'b0}} : rs_stall_r;
  assign rob_stall_cycles = reset ? {CNT_W{1'b0}} : rob_stall_r;

  // Entry storage; written only on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= enq_pack;
    end
  end

  // Pointers, occupancy and the RUN/HALTED state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_Q_W{1'b0}};
      state_r <= RUN;
    end else if (squash) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_Q_W{1'b0}};
      state_r <= RUN;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (fire_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, fire_s})
        2'b10:   count_r <= count_r + CNT_Q_W'(1);
        2'b01:   count_r <= count_r - CNT_Q_W'(1);
        default: count_r <= count_r;
      endcase
      case (state_r)
        RUN: begin
          if (fire_s && head_halt_s) begin
            state_r <= HALTED;
          end else begin
            state_r <= RUN;
          end
        end
        HALTED:  state_r <= HALTED;
        default: state_r <= RUN;
      endcase
    end
  end

  // Saturating stall counters; a full ROB takes precedence over a full RS.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_stall_r  <= {CNT_W{1'b0}};
      rob_stall_r <= {CNT_W{1'b0}};
    end else if (active_s && rob_full) begin
      rob_stall_r <= sat_inc(rob_stall_r);
    end else if (active_s && rs_full_s) begin
      rs_stall_r <= sat_inc(rs_stall_r);
    end
  end

endmodule

// File: tb/tb_dispatch_iq.sv
// tb_dispatch_iq: directed stimulus with a scoreboard of expected dispatches checked by an independent monitor.
module tb_dispatch_iq;
  localparam int NUM_FU = 4;
  localparam int CNT_W  = 32;
  localparam int PACK_W = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              enq_valid;
  logic [PACK_W-1:0] enq_pack;
  logic              enq_ready;
  logic              rob_full;
  logic [NUM_FU-1:0] RS_is_full;
  logic              squash;
  logic              dispatch_valid;
  logic [PACK_W-1:0] dispatch_pack;
  logic [NUM_FU-1:0] RS_load;
  logic [3:0]        iq_count;
  logic              halted;
  logic [CNT_W-1:0]  rs_stall_cycles;
  logic [CNT_W-1:0]  rob_stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [PACK_W-1:0] pack;
    logic [NUM_FU-1:0] load;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  dispatch_iq dut (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_pack(enq_pack), .enq_ready(enq_ready),
    .rob_full(rob_full), .RS_is_full(RS_is_full), .squash(squash), .dispatch_valid(dispatch_valid),
    .dispatch_pack(dispatch_pack), .RS_load(RS_load), .iq_count(iq_count), .halted(halted),
    .rs_stall_cycles(rs_stall_cycles), .rob_stall_cycles(rob_stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [PACK_W-1:0] mk(input logic [15:0] pl, input logic h, input logic [2:0] fu);
    return {pl, h, fu};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic enq(input logic [PACK_W-1:0] p, input logic [NUM_FU-1:0] load);
    enq_valid = 1'b1;
    enq_pack  = p;
    exp_q.push_back({p, load});
  endtask

  // Monitor: every dispatch must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dispatch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dispatch: got pack %0h expected no dispatch at %0t", dispatch_pack, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dispatch_pack", 32'(dispatch_pack), 32'(mon_e.pack));
        chk("RS_load", 32'(RS_load), 32'(mon_e.load));
      end
    end
  end

  initial begin
    reset = 1'b1; enq_valid = 1'b1; enq_pack = mk(16'hdead, 1'b0, 3'd3);
    rob_full = 1'b0; RS_is_full = 4'b0000; squash = 1'b0;

    // power-on reset
    mid;
    chk("rst_enq_ready", 32'(enq_ready), 32'd0);
    chk("rst_dispatch_valid", 32'(dispatch_valid), 32'd0);
    chk("rst_iq_count", 32'(iq_count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_rs_load", 32'(RS_load), 32'd0);
    tick;
    reset = 1'b0; enq_valid = 1'b0;
    mid;
    chk("post_rst_count", 32'(iq_count), 32'd0);
    chk("post_rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("post_rst_rs_stall", rs_stall_cycles, 32'd0);
    chk("post_rst_rob_stall", rob_stall_cycles, 32'd0);
    tick;

    // 1: three ALU packets back-to-back
    enq(mk(16'h0001, 1'b0, 3'd3), 4'b1000); mid; chk("t1_c1_dv", 32'(dispatch_valid), 32'd0); tick;
    enq(mk(16'h0002, 1'b0, 3'd3), 4'b1000); mid; chk("t1_c2_dv", 32'(dispatch_valid), 32'd1);
    chk("t1_c2_cnt", 32'(iq_count), 32'd1); tick;
    enq(mk(16'h0003, 1'b0, 3'd3), 4'b1000); mid; chk("t1_c3_dv", 32'(dispatch_valid), 32'd1);
    chk("t1_c3_cnt", 32'(iq_count), 32'd1); tick;
    enq_valid = 1'b0; mid; chk("t1_c4_dv", 32'(dispatch_valid), 32'd1); chk("t1_c4_cnt", 32'(iq_count), 32'd1); tick;
    mid; chk("t1_c5_dv", 32'(dispatch_valid), 32'd0); chk("t1_c5_cnt", 32'(iq_count), 32'd0); tick;

    // 2: fill with ALU RS full, then drain
    RS_is_full = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      enq(mk(16'h0100 + 16'(i), 1'b0, 3'd3), 4'b1000);
      mid; chk("t2_fill_ready", 32'(enq_ready), 32'd1); tick;
    end
    enq_valid = 1'b1; enq_pack = mk(16'h01ff, 1'b0, 3'd3);
    mid; chk("t2_full_cnt", 32'(iq_count), 32'd8); chk("t2_full_ready", 32'(enq_ready), 32'd0);
    chk("t2_full_dv", 32'(dispatch_valid), 32'd0); chk("t2_full_load", 32'(RS_load), 32'd0); tick;
    enq_valid = 1'b0; mid; tick;
    RS_is_full = 4'b0000; enq_valid = 1'b1; enq_pack = mk(16'h02ff, 1'b0, 3'd3);
    mid; chk("t2_no_passthru", 32'(enq_ready), 32'd0); chk("t2_rel_cnt", 32'(iq_count), 32'd8);
    chk("t2_rs_stall", rs_stall_cycles, 32'd9); chk("t2_rel_dv", 32'(dispatch_valid), 32'd1); tick;
    enq_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      mid; chk("t2_drain_cnt", 32'(iq_count), 32'(8 - k)); chk("t2_drain_dv", 32'(dispatch_valid), 32'd1); tick;
    end
    mid; chk("t2_empty_cnt", 32'(iq_count), 32'd0); chk("t2_empty_dv", 32'(dispatch_valid), 32'd0); tick;

    // 3: ROB and RS both full for 5 cycles -> ROB counter only
    enq(mk(16'h0300, 1'b0, 3'd3), 4'b1000); mid; tick;
    enq_valid = 1'b0; rob_full = 1'b1; RS_is_full = 4'b1000;
    repeat (5) begin
      mid; chk("t3_stall_dv", 32'(dispatch_valid), 32'd0); tick;
    end
    rob_full = 1'b0; RS_is_full = 4'b0000;
    mid; chk("t3_rob_stall", rob_stall_cycles, 32'd5); chk("t3_rs_stall", rs_stall_cycles, 32'd9);
    chk("t3_dv", 32'(dispatch_valid), 32'd1); tick;
    mid; chk("t3_cnt", 32'(iq_count), 32'd0); tick;

    // 4: blocked MULT head keeps a younger ALU waiting
    RS_is_full = 4'b0010;
    enq(mk(16'h0400, 1'b0, 3'd1), 4'b0010); mid; tick;
    enq(mk(16'h0401, 1'b0, 3'd3), 4'b1000); mid;
    chk("t4_c2_dv", 32'(dispatch_valid), 32'd0); chk("t4_c2_load", 32'(RS_load), 32'd0); tick;
    enq_valid = 1'b0; mid;
    chk("t4_c3_dv", 32'(dispatch_valid), 32'd0); chk("t4_c3_load", 32'(RS_load), 32'd0);
    chk("t4_c3_cnt", 32'(iq_count), 32'd2); chk("t4_head_shown", 32'(dispatch_pack), 32'(mk(16'h0400, 1'b0, 3'd1)));
    tick;
    RS_is_full = 4'b0000; mid; chk("t4_rel_dv", 32'(dispatch_valid), 32'd1); chk("t4_rs_stall", rs_stall_cycles, 32'd11); tick;
    mid; chk("t4_alu_dv", 32'(dispatch_valid), 32'd1); tick;
    mid; chk("t4_cnt", 32'(iq_count), 32'd0); tick;

    // illegal fu drains with no RS strobe, ignoring RS_is_full
    RS_is_full = 4'b1111;
    enq(mk(16'h0500, 1'b0, 3'd5), 4'b0000); mid; tick;
    enq_valid = 1'b0; mid; chk("ill_dv", 32'(dispatch_valid), 32'd1); chk("ill_load", 32'(RS_load), 32'd0); tick;
    mid; chk("ill_cnt", 32'(iq_count), 32'd0); chk("ill_rs_stall", rs_stall_cycles, 32'd11); tick;

    // 5: squash with 5 entries queued
    for (int i = 0; i < 5; i++) begin
      enq(mk(16'h0600 + 16'(i), 1'b0, 3'd3), 4'b1000); mid; tick;
    end
    squash = 1'b1; enq_valid = 1'b1; enq_pack = mk(16'h06ff, 1'b0, 3'd3); RS_is_full = 4'b0000;
    exp_q.delete();
    mid; chk("t5_sq_dv", 32'(dispatch_valid), 32'd0); chk("t5_sq_load", 32'(RS_load), 32'd0);
    chk("t5_sq_ready", 32'(enq_ready), 32'd0); chk("t5_sq_cnt", 32'(iq_count), 32'd5); tick;
    squash = 1'b0; enq_valid = 1'b0;
    mid; chk("t5_cnt", 32'(iq_count), 32'd0); chk("t5_ready", 32'(enq_ready), 32'd1);
    chk("t5_dv", 32'(dispatch_valid), 32'd0); chk("t5_rs_stall", rs_stall_cycles, 32'd15); tick;

    // 6: halt packet, then squash releases it
    enq(mk(16'h0700, 1'b1, 3'd3), 4'b1000); mid; tick;
    enq(mk(16'h0701, 1'b0, 3'd3), 4'b1000); mid;
    chk("t6_halt_dv", 32'(dispatch_valid), 32'd1); chk("t6_pre_halted", 32'(halted), 32'd0); tick;
    enq_valid = 1'b1; enq_pack = mk(16'h07ff, 1'b0, 3'd3);
    mid; chk("t6_halted", 32'(halted), 32'd1); chk("t6_ready", 32'(enq_ready), 32'd0);
    chk("t6_dv", 32'(dispatch_valid), 32'd0); chk("t6_cnt", 32'(iq_count), 32'd1); tick;
    enq_valid = 1'b0; mid; chk("t6_hold_dv", 32'(dispatch_valid), 32'd0); chk("t6_hold_halted", 32'(halted), 32'd1); tick;
    squash = 1'b1; exp_q.delete(); mid; chk("t6_sq_dv", 32'(dispatch_valid), 32'd0); tick;
    squash = 1'b0; mid;
    chk("t6_unhalt", 32'(halted), 32'd0); chk("t6_sq_cnt", 32'(iq_count), 32'd0); chk("t6_sq_ready", 32'(enq_ready), 32'd1);
    tick;

    // reset mid-operation
    RS_is_full = 4'b1000;
    enq(mk(16'h0800, 1'b0, 3'd3), 4'b1000); mid; tick;
    enq(mk(16'h0801, 1'b0, 3'd3), 4'b1000); mid; tick;
    reset = 1'b1; enq_valid = 1'b0; exp_q.delete();
    mid; chk("mrst_ready", 32'(enq_ready), 32'd0); chk("mrst_cnt", 32'(iq_count), 32'd0);
    chk("mrst_dv", 32'(dispatch_valid), 32'd0); tick;
    reset = 1'b0; RS_is_full = 4'b0000;
    mid; chk("mrst_post_cnt", 32'(iq_count), 32'd0); chk("mrst_rs_stall", rs_stall_cycles, 32'd0);
    chk("mrst_rob_stall", rob_stall_cycles, 32'd0); chk("mrst_dv2", 32'(dispatch_valid), 32'd0);
    chk("mrst_ready2", 32'(enq_ready), 32'd1); tick;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
